sawtooth_sched: RTL and testbench

- Round-robin scheduler that shares one pipelined sawtooth unit among NUM_REQ requesters, e.g. the per-channel chaotic-map iterators.
- Accepts (x, epsilon) operand pairs and issues at most one per cycle to the unit.
- Tags each issued operation with its requester ID in an in-order tag FIFO, and routes each returning result back to its owner.
- The sawtooth unit has fixed latency, in-order results and no backpressure; this block enforces an in-flight limit instead.

---
 rtl/sawtooth_pkg.sv | 22 ++
 rtl/sawtooth_tag_fifo.sv | 58 +++++
 rtl/sawtooth_sched.sv | 154 +++++++++++++++
 tb/tb_sawtooth_sched.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sawtooth_pkg.sv
// sawtooth_pkg
// Shared constants and helpers for the sawtooth scheduler slice.
//   FP_ONE / FP_HALF : IEEE-754 single-precision 1.0 and 0.5
//   id_width()       : requester-ID width for a given requester count
//   req_id_t         : requester ID type for the default requester count
package sawtooth_pkg;

  localparam logic [31:0] FP_ONE  = 32'h3F800000;
  localparam logic [31:0] FP_HALF = 32'h3F000000;

  localparam int NUM_REQ_DEF = 4;

  // A single requester still needs a 1-bit ID so vectors never collapse to zero width.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int REQ_ID_W = id_width(NUM_REQ_DEF);

  typedef logic [REQ_ID_W-1:0] req_id_t;

endpackage

// File: rtl/sawtooth_tag_fifo.sv
// sawtooth_tag_fifo
// Synchronous FIFO holding the requester ID of every operation in flight in
// the sawtooth unit. DEPTH must be a power of two.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   push, din    write strobe and data (a push at full is taken only with a same-cycle pop)
//   pop, dout    read strobe and head-of-queue data (pop while empty is ignored)
//   full, empty  occupancy flags
//   count        current occupancy, 0..DEPTH
module sawtooth_tag_fifo #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/sawtooth_sched.sv
// sawtooth_sched
// Round-robin scheduler sharing one fixed-latency, in-order sawtooth unit
// among NUM_REQ requesters. Issued operations are tagged with their owner ID
// in a tag FIFO; returning results are routed back to that owner. The tag
// FIFO depth is the in-flight limit, checked at acceptance time.
// Ports:
//   clk, reset                   clock, asynchronous active-high reset
//   req_valid/req_ready          per-requester handshake (ready is one-hot or zero)
//   req_x/req_epsilon            packed operands, requester i at [i*PRECISION +: PRECISION]
//   resp_valid/resp_data         one-cycle result strobe to the owner, shared data bus
//   saw_tvalid/saw_x/saw_epsilon issue to the sawtooth unit
//   saw_valid/saw_result         result from the sawtooth unit
//   busy                         operations outstanding or issue in progress
//   err_orphan                   sticky: unit returned a result with no tag pending
// Build option SAWTOOTH_SCHED_STATS_EN adds stat_issued (transfers) and
// stat_stall (cycles blocked by the in-flight limit), both 32-bit wrapping.
module sawtooth_sched
  import sawtooth_pkg::*;
#(
  parameter int PRECISION    = 32,
  parameter int NUM_REQ      = 4,
  parameter int MAX_INFLIGHT = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*PRECISION-1:0] req_x,
  input  logic [NUM_REQ*PRECISION-1:0] req_epsilon,
  output logic [NUM_REQ-1:0]           resp_valid,
  output logic [PRECISION-1:0]         resp_data,
  output logic                         saw_tvalid,
  output logic [PRECISION-1:0]         saw_x,
  output logic [PRECISION-1:0]         saw_epsilon,
  input  logic                         saw_valid,
  input  logic [PRECISION-1:0]         saw_result,
  output logic                         busy,
  output logic                         err_orphan
`ifdef SAWTOOTH_SCHED_STATS_EN
  ,
  output logic [31:0]                  stat_issued,
  output logic [31:0]                  stat_stall
`endif
);

  localparam int ID_W = id_width(NUM_REQ);

  logic [ID_W-1:0]              ptr_q, ptr_d;
  logic [ID_W-1:0]              grant_id;
  logic                         grant_any;
  logic [NUM_REQ-1:0]           eligible;
  logic                         xfer;

  logic                         saw_tvalid_q;
  logic [PRECISION-1:0]         saw_x_q, saw_eps_q;
  logic [NUM_REQ-1:0]           resp_valid_q;
  logic [PRECISION-1:0]         resp_data_q;
  logic                         err_q;

  logic                         tag_full, tag_empty, tag_pop;
  logic [ID_W-1:0]              tag_id;
  logic [$clog2(MAX_INFLIGHT):0] tag_count;

  // The tag FIFO occupancy is the in-flight count. Reset gates grants so
  // req_ready reads zero while reset is asserted.
  always_comb begin
    eligible  = req_valid & {NUM_REQ{!tag_full && !reset}};
    grant_any = 1'b0;
    grant_id  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_any && eligible[(int'(ptr_q) + k) % NUM_REQ]) begin
        grant_any = 1'b1;
        grant_id  = ID_W'((int'(ptr_q) + k) % NUM_REQ);
      end
    end
    req_ready = '0;
    if (grant_any) req_ready[grant_id] = 1'b1;
  end

  assign xfer    = grant_any;
  assign tag_pop = saw_valid && !tag_empty;

  always_comb begin
    ptr_d = ptr_q;
    if (xfer) ptr_d = (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;
  end

  sawtooth_tag_fifo #(
    .DEPTH (MAX_INFLIGHT),
    .WIDTH (ID_W)
  ) u_tag_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (xfer),
    .din   (grant_id),
    .pop   (tag_pop),
    .dout  (tag_id),
    .full  (tag_full),
    .empty (tag_empty),
    .count (tag_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q        <= '0;
      saw_tvalid_q <= 1'b0;
      saw_x_q      <= '0;
      saw_eps_q    <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      ptr_q        <= ptr_d;
      saw_tvalid_q <= xfer;
      if (xfer) begin
        saw_x_q   <= req_x[grant_id*PRECISION +: PRECISION];
        saw_eps_q <= req_epsilon[grant_id*PRECISION +: PRECISION];
      end
      resp_valid_q <= '0;
      if (tag_pop) begin
        resp_valid_q[tag_id] <= 1'b1;
        resp_data_q          <= saw_result;
      end
      // A result with no tag (e.g. draining after reset) is dropped and flagged.
      if (saw_valid && tag_empty) err_q <= 1'b1;
    end
  end

  assign saw_tvalid  = saw_tvalid_q;
  assign saw_x       = saw_x_q;
  assign saw_epsilon = saw_eps_q;
  assign resp_valid  = resp_valid_q;
  assign resp_data   = resp_data_q;
  assign err_orphan  = err_q;
  assign busy        = (tag_count != '0) || saw_tvalid_q;

`ifdef SAWTOOTH_SCHED_STATS_EN
  logic [31:0] stat_issued_q, stat_stall_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_issued_q <= '0;
      stat_stall_q  <= '0;
    end else begin
      if (xfer) stat_issued_q <= stat_issued_q + 32'd1;
      if ((|req_valid) && tag_full) stat_stall_q <= stat_stall_q + 32'd1;
    end
  end

  assign stat_issued = stat_issued_q;
  assign stat_stall  = stat_stall_q;
`endif

endmodule

// File: tb/tb_sawtooth_sched.sv
`timescale 1ns/1ps
module tb_sawtooth_sched;
  import sawtooth_pkg::*;

  localparam int P    = 32;
  localparam int NR   = 4;
  localparam int MAXF = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [NR-1:0]   req_valid = '0;
  logic [NR-1:0]   req_ready;
  logic [NR*P-1:0] req_x, req_epsilon;
  logic [NR-1:0]   resp_valid;
  logic [P-1:0]    resp_data;
  logic            saw_tvalid;
  logic [P-1:0]    saw_x, saw_epsilon;
  logic            saw_valid = 1'b0;
  logic [P-1:0]    saw_result = '0;
  logic            busy, err_orphan;
`ifdef SAWTOOTH_SCHED_STATS_EN
  logic [31:0]     stat_issued, stat_stall;
`endif

  logic [P-1:0] drv_x [NR];
  logic [P-1:0] drv_e [NR];

  for (genvar gi = 0; gi < NR; gi++) begin : g_pack
    assign req_x[gi*P +: P]       = drv_x[gi];
    assign req_epsilon[gi*P +: P] = drv_e[gi];
  end

  sawtooth_sched #(
    .PRECISION    (P),
    .NUM_REQ      (NR),
    .MAX_INFLIGHT (MAXF)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_x       (req_x),
    .req_epsilon (req_epsilon),
    .resp_valid  (resp_valid),
    .resp_data   (resp_data),
    .saw_tvalid  (saw_tvalid),
    .saw_x       (saw_x),
    .saw_epsilon (saw_epsilon),
    .saw_valid   (saw_valid),
    .saw_result  (saw_result),
    .busy        (busy),
    .err_orphan  (err_orphan)
`ifdef SAWTOOTH_SCHED_STATS_EN
    ,
    .stat_issued (stat_issued),
    .stat_stall  (stat_stall)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // ---------------- environment: stub unit + reference model ----------------
  typedef struct { int due; logic [31:0] res; } stub_t;
  stub_t stub_q[$];
  int    lat = 2;
  int    cyc = 0;

  int            own_q[$];       // owners of operations accepted and not yet returned
  int            ptr_m = 0;
  logic          exp_tv = 1'b0;
  logic [31:0]   exp_sx = '0, exp_se = '0;
  logic [NR-1:0] exp_rv = '0;
  logic [31:0]   exp_rd = '0;
  logic          err_m = 1'b0;
  logic [NR-1:0] last_grant = '0;
  int            n_xfer_m = 0, n_stall_m = 0;
  int            act_resp_cnt [NR];
  bit            chk_cap = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : mon
    logic [NR-1:0] g;
    int gi;
    int idx;
    if (reset) begin
      chk("rst_ready",      32'(req_ready),  32'd0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_tvalid",     32'(saw_tvalid), 32'd0);
      chk("rst_busy",       32'(busy),       32'd0);
      chk("rst_err",        32'(err_orphan), 32'd0);
      ptr_m = 0; own_q.delete(); exp_tv = 1'b0; exp_rv = '0; err_m = 1'b0;
      last_grant = '0; n_xfer_m = 0; n_stall_m = 0;
    end else begin
      chk("saw_tvalid", 32'(saw_tvalid), 32'(exp_tv));
      if (exp_tv) begin
        chk("saw_x",       saw_x,       exp_sx);
        chk("saw_epsilon", saw_epsilon, exp_se);
      end
      chk("resp_valid", 32'(resp_valid), 32'(exp_rv));
      if (exp_rv != '0) chk("resp_data", resp_data, exp_rd);
      chk("err_orphan", 32'(err_orphan), 32'(err_m));
      chk("busy", 32'(busy), 32'((own_q.size() != 0) || exp_tv));
      for (int i = 0; i < NR; i++) if (resp_valid[i]) act_resp_cnt[i]++;
    end

    // Stub unit: fixed latency, in order, stand-in transform of the operands.
    if (saw_tvalid) stub_q.push_back('{cyc + lat, saw_x ^ saw_epsilon ^ FP_ONE});
    saw_valid = 1'b0;
    if (stub_q.size() > 0 && stub_q[0].due == cyc) begin
      saw_valid  = 1'b1;
      saw_result = stub_q[0].res;
      void'(stub_q.pop_front());
    end

    if (!reset) begin
      g  = '0;
      gi = 0;
      if (own_q.size() < MAXF) begin
        for (int k = 0; k < NR; k++) begin
          idx = (ptr_m + k) % NR;
          if (g == '0 && req_valid[idx]) begin g[idx] = 1'b1; gi = idx; end
        end
      end
      chk("grant", 32'(req_ready), 32'(g));
      if (req_valid != '0 && own_q.size() == MAXF) n_stall_m++;
      exp_rv = '0;
      if (saw_valid) begin
        if (own_q.size() > 0) begin
          exp_rv[own_q.pop_front()] = 1'b1;
          exp_rd = saw_result;
        end else begin
          err_m = 1'b1;
        end
      end
      exp_tv = (g != '0);
      if (g != '0) begin
        own_q.push_back(gi);
        exp_sx = drv_x[gi];
        exp_se = drv_e[gi];
        ptr_m  = (gi + 1) % NR;
        n_xfer_m++;
      end
      last_grant = g;
      if (chk_cap) chk("inflight_cap", 32'(stub_q.size() <= MAXF), 32'd1);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic [NR-1:0] want);
    @(posedge clk); #1;
    for (int i = 0; i < NR; i++) begin
      if (last_grant[i] || !req_valid[i]) begin
        drv_x[i] = $urandom;
        drv_e[i] = $urandom;
      end
      req_valid[i] = want[i];
    end
  endtask

  task automatic drive_rand();
    @(posedge clk); #1;
    for (int i = 0; i < NR; i++) begin
      if (!(req_valid[i] && !last_grant[i])) begin
        drv_x[i]     = $urandom;
        drv_e[i]     = $urandom;
        req_valid[i] = ($urandom_range(0, 99) < 60);
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    reset = 1'b1; req_valid = '0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((own_q.size() != 0 || stub_q.size() != 0 || saw_tvalid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("drain_timeout", 32'(n), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic clr_resp_cnt();
    for (int i = 0; i < NR; i++) act_resp_cnt[i] = 0;
  endtask

  typedef struct { logic [NR-1:0] vld; logic [NR-1:0] rdy; } vec_t;
  vec_t tbl [10];

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int sum;
    for (int i = 0; i < NR; i++) begin drv_x[i] = '0; drv_e[i] = '0; act_resp_cnt[i] = 0; end

    // Arbitration vectors from reset (ptr starts at 0), each row one cycle.
    tbl[0] = '{4'b1111, 4'b0001};
    tbl[1] = '{4'b1111, 4'b0010};
    tbl[2] = '{4'b0001, 4'b0001};
    tbl[3] = '{4'b0000, 4'b0000};
    tbl[4] = '{4'b1001, 4'b1000};
    tbl[5] = '{4'b0110, 4'b0010};
    tbl[6] = '{4'b0110, 4'b0100};
    tbl[7] = '{4'b0110, 4'b0010};
    tbl[8] = '{4'b1000, 4'b1000};
    tbl[9] = '{4'b1111, 4'b0001};

    repeat (2) @(posedge clk);
    #3 reset = 1'b0;

    lat = 2;
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].vld);
      @(negedge clk);
      chk($sformatf("tbl%0d_ready", i), 32'(req_ready), 32'(tbl[i].rdy));
    end
    drive('0);
    drain();

    // Single op latency: 0.5 with eps=1.0 comes back unchanged after L+2 cycles.
    do_reset();
    lat = 5;
    drive(4'b0001);
    drv_x[0] = FP_HALF;
    drv_e[0] = FP_ONE;
    @(negedge clk);
    t0 = cyc;
    chk("single_ready", 32'(req_ready), 32'h1);
    drive('0);
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (resp_valid != '0) break;
    end
    chk("single_latency", 32'(cyc - t0), 32'(lat + 2));
    chk("single_resp_valid", 32'(resp_valid), 32'h1);
    chk("single_resp_data", resp_data, FP_HALF);
    drain();

    // All four requesters hold valid for 8 cycles.
    do_reset();
    lat = 2;
    clr_resp_cnt();
    for (int k = 0; k < 8; k++) begin
      drive(4'b1111);
      @(negedge clk);
      chk($sformatf("rr_order%0d", k), 32'(req_ready), 32'(1 << (k % 4)));
    end
    drive('0);
    drain();
    for (int i = 0; i < NR; i++) chk($sformatf("rr_resp_cnt%0d", i), 32'(act_resp_cnt[i]), 32'd2);

    // Requester 2 streams into a latency-10 unit with a limit of 4.
    do_reset();
    lat = 10;
    chk_cap = 1'b1;
    for (int k = 0; k < 24; k++) begin
      drive(4'b0100);
      @(negedge clk);
      if (k < 13) chk($sformatf("stall_ready%0d", k), 32'(req_ready[2]), 32'(k < 4 || k == 12));
    end
    drive('0);
    drain();
    chk_cap = 1'b0;
`ifdef SAWTOOTH_SCHED_STATS_EN
    chk("stat_issued", stat_issued, 32'(n_xfer_m));
    chk("stat_stall",  stat_stall,  32'(n_stall_m));
`endif

    // Reset with three operations in flight; their results become orphans.
    do_reset();
    lat = 10;
    repeat (3) drive(4'b0010);
    drive('0);
    repeat (3) @(negedge clk);
    @(posedge clk); #3;
    reset = 1'b1;
    req_valid = 4'b1111;
    #1;
    chk("mid_rst_ready",  32'(req_ready),  32'd0);
    chk("mid_rst_resp",   32'(resp_valid), 32'd0);
    chk("mid_rst_tvalid", 32'(saw_tvalid), 32'd0);
    chk("mid_rst_busy",   32'(busy),       32'd0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    req_valid = '0;
    clr_resp_cnt();
    drain();
    sum = 0;
    for (int i = 0; i < NR; i++) sum += act_resp_cnt[i];
    chk("orphan_no_resp", 32'(sum), 32'd0);
    chk("orphan_err", 32'(err_orphan), 32'd1);
    repeat (3) @(negedge clk);
    chk("orphan_sticky", 32'(err_orphan), 32'd1);
    do_reset();
    @(negedge clk);
    chk("orphan_cleared", 32'(err_orphan), 32'd0);

    // Randomised traffic with varying unit latency.
    for (int ph = 0; ph < 6; ph++) begin
      drain();
      lat = $urandom_range(1, 12);
      repeat (300) drive_rand();
      drive('0);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
